// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller.
//   OP_ILLEGAL            reserved opcode, produces an error result without an ALU cycle
//   OP_MULTI_LO/HI        inclusive opcode range that needs the long EXEC latency
//   CNT_W                 width of the EXEC latency counter
//   state_t               controller state encoding
//   is_multi()            true for opcodes in the multi-cycle range
package alu_seq_ctrl_pkg;

    localparam logic [3:0] OP_ILLEGAL  = 4'hF;
    localparam logic [3:0] OP_MULTI_LO = 4'hC;
    localparam logic [3:0] OP_MULTI_HI = 4'hE;
    localparam int         CNT_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CAPT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return (op >= OP_MULTI_LO) && (op <= OP_MULTI_HI);
    endfunction

endpackage

// File: rtl/alu_lat_cnt.sv
// Loadable down-counter that times the EXEC phase of an ALU operation.
//   clk_in    clock, rising edge
//   rst       asynchronous active-low reset (count -> 0)
//   load      load load_val (has priority over dec)
//   load_val  latency to load
//   dec       decrement request; the count holds at 1 instead of wrapping
//   is_one    count equals 1 (last EXEC cycle)
module alu_lat_cnt
    import alu_seq_ctrl_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt > CNT_W'(1))) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one ALU operation at a time between a requester and the ALU/out_reg pair.
//   clk_in, rst                     clock and asynchronous active-low reset
//   req_valid/req_ready             request handshake carrying req_op, req_a, req_b
//   alu_op, alu_a, alu_b            latched operation driven to the ALU
//   alu_res, alu_carry              ALU result inputs
//   out_ld                          one-cycle load strobe to out_reg
//   res_valid/res_ready             result handshake carrying res_data, res_carry, res_err
//   busy                            controller is not idle
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request, req_ready high once out of reset
// EXEC   | ALU driven with latched operands, latency counter running
// CAPT   | out_ld pulse; ALU result (or error result) captured
// DONE   | result presented; may accept the next request on the same edge
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MULTI_LAT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    output logic             out_ld,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MULTI_LAT_C = CNT_W'(MULTI_LAT);

    state_t           state;
    logic             started;
    logic             op_err;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_is_one;

    // started keeps req_ready low until the first edge after reset release.
    assign req_ready    = ((state == S_IDLE) && started) || ((state == S_DONE) && res_ready);
    assign accept       = req_valid && req_ready;
    assign cnt_load     = accept && (req_op != OP_ILLEGAL);
    assign cnt_load_val = is_multi(req_op) ? MULTI_LAT_C : CNT_W'(1);

    alu_lat_cnt u_lat_cnt (
        .clk_in   (clk_in),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (state == S_EXEC),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            started   <= 1'b0;
            op_err    <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            out_ld    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            started <= 1'b1;
            out_ld  <= 1'b0;
            if (accept) begin
                // Accept is possible from IDLE or, back-to-back, from DONE.
                alu_op    <= req_op;
                alu_a     <= req_a;
                alu_b     <= req_b;
                op_err    <= (req_op == OP_ILLEGAL);
                res_valid <= 1'b0;
                busy      <= 1'b1;
                // Illegal ops skip EXEC but still take the CAPT cycle, without out_ld.
                state     <= (req_op == OP_ILLEGAL) ? S_CAPT : S_EXEC;
            end else begin
                unique case (state)
                    S_EXEC: begin
                        if (cnt_is_one) begin
                            state  <= S_CAPT;
                            out_ld <= 1'b1;
                        end
                    end
                    S_CAPT: begin
                        state     <= S_DONE;
                        res_valid <= 1'b1;
                        if (op_err) begin
                            res_data  <= '0;
                            res_carry <= 1'b0;
                            res_err   <= 1'b1;
                        end else begin
                            res_data  <= alu_res;
                            res_carry <= alu_carry;
                            res_err   <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        if (res_ready) begin
                            state     <= S_IDLE;
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
